mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Purpose: sequences one dot product over the A/B operand memories through an external MAC.
// Latency: result and done appear len+2 edges after start is sampled (1 edge when len=0).
// Backpressure: none; start is ignored while busy, and abort returns to IDLE on the next edge.
module mac_seq_ctrl #(
  parameter int Nbits  = 4,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      len,
  input  logic                 abort,
  output logic [ADDR_W-1:0]    addr,
  input  logic [Nbits-1:0]     a_data,
  input  logic [Nbits-1:0]     b_data,
  output logic                 mac_reset,
  output logic [Nbits-1:0]     mac_multiplier,
  output logic [Nbits-1:0]     mac_multiplicand,
  input  logic [2*Nbits-1:0]   mac_acc,
  output logic                 busy,
  output logic                 done,
  output logic [2*Nbits-1:0]   result
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_last;
  logic                 r_valid_d;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mac_reset;
  logic [2*Nbits-1:0]   r_result;

  logic [ADDR_W:0]      w_len_sat;
  logic [ADDR_W:0]      w_len_m1;
  logic [ADDR_W-1:0]    w_last;

  // Lengths beyond the memory depth are clamped so addr never wraps.
  assign w_len_sat = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
  assign w_len_m1  = w_len_sat - (ADDR_W+1)'(1);
  assign w_last    = w_len_m1[ADDR_W-1:0];

  // Control FSM; busy/mac_reset are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_last      <= '0;
      r_valid_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mac_reset <= 1'b1;
      r_result    <= '0;
    end else begin
      r_done    <= 1'b0;
      // Memory read is synchronous, so data for a RUN-cycle address arrives one cycle later.
      r_valid_d <= (r_state == RUN);
      case (r_state)
        IDLE: begin
          // abort outranks start here; addr already sits at 0.
          if (start && !abort) begin
            r_busy      <= 1'b1;
            r_mac_reset <= 1'b0;
            r_addr      <= '0;
            r_last      <= w_last;
            if (w_len_sat == '0) begin
              r_state <= CAPTURE;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_mac_reset <= 1'b1;
          end else if (r_addr == r_last) begin
            // Hold the final address; the last operand pair is still in flight.
            r_state <= DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_mac_reset <= 1'b1;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_state     <= IDLE;
          r_addr      <= '0;
          r_busy      <= 1'b0;
          r_mac_reset <= 1'b1;
          // An abort here discards the capture: result keeps the previous value.
          if (!abort) begin
            r_result <= mac_acc;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_addr      <= '0;
          r_busy      <= 1'b0;
          r_mac_reset <= 1'b1;
        end
      endcase
    end
  end

  assign addr             = r_addr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign result           = r_result;
  assign mac_reset        = r_mac_reset;
  // Zero operands outside valid data cycles keep the accumulator unchanged.
  assign mac_multiplier   = r_valid_d ? a_data : '0;
  assign mac_multiplicand = r_valid_d ? b_data : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a synchronous-read memory model and a MAC model.
// Expected results are queued at start; a monitor pops them on each done pulse.
// Directed vectors with hand-computed dot products and done timing.
module tb_mac_seq_ctrl;
  localparam int NB = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic          abort;
  logic [AW-1:0] addr;
  logic [NB-1:0] a_data;
  logic [NB-1:0] b_data;
  logic          mac_reset;
  logic [NB-1:0] mult;
  logic [NB-1:0] mcand;
  logic [2*NB-1:0] mac_acc;
  logic          busy;
  logic          done;
  logic [2*NB-1:0] result;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [NB-1:0] mem_a[8];
  logic [NB-1:0] mem_b[8];

  mac_seq_ctrl #(.Nbits(NB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
    .addr(addr), .a_data(a_data), .b_data(b_data), .mac_reset(mac_reset),
    .mac_multiplier(mult), .mac_multiplicand(mcand), .mac_acc(mac_acc),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a_data <= mem_a[addr];
    b_data <= mem_b[addr];
  end

  always @(posedge clk) begin
    if (mac_reset) mac_acc <= '0;
    else           mac_acc <= mac_acc + mult * mcand;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: result=%0d at cycle %0d with nothing pending", result, cyc);
      end else begin
        e = sb.pop_front();
        chk("done_result", {24'd0, result}, {24'd0, e.res});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [AW:0] l, input logic [7:0] res, input int lat);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{res: res, cyc: cyc + lat});
  endtask

  task automatic start_only(input logic [AW:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_within_budget", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea2[7];
    int em2[7];
    int ea3[11];
    ea2 = '{0, 1, 2, 3, 3, 3, 0};
    em2 = '{0, 1, 2, 3, 4, 0, 0};
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 4'(i + 1);
      mem_b[i] = 4'd1;
    end
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;

    // Reset held for five cycles
    repeat (5) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mac_reset", mac_reset, 1);
    chk("rst_mult", mult, 0);
    chk("rst_mcand", mcand, 0);
    reset = 1'b0;

    // len=4, A={1,2,3,4}, B=1 -> 10 after E6
    issue(5'(4), 8'd10, 6);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("len4_addr", addr, ea2[k]);
      chk("len4_busy", busy, (k < 6) ? 1 : 0);
      chk("len4_mac_reset", mac_reset, (k < 6) ? 0 : 1);
      chk("len4_mult", mult, em2[k]);
    end

    // len=8, all 15 -> 1800 mod 256 = 8 after E10; addr stops at 7
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 4'd15;
      mem_b[i] = 4'd15;
    end
    for (int k = 0; k < 11; k++) ea3[k] = (k < 8) ? k : ((k < 10) ? 7 : 0);
    issue(5'(8), 8'd8, 10);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("len8_addr", addr, ea3[k]);
    end

    // len=0 -> result 0 after E1
    issue(5'(0), 8'd0, 1);
    @(negedge clk);
    chk("len0_busy_k0", busy, 1);
    wait_idle(5);

    // len=2, A={3,5}, B={2,4} -> 26, no carry-over
    mem_a[0] = 4'd3; mem_a[1] = 4'd5;
    mem_b[0] = 4'd2; mem_b[1] = 4'd4;
    issue(5'(2), 8'd26, 4);
    wait_idle(10);

    // len=12 saturates to 8: A={1..8}, B=1 -> 36 after E10
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 4'(i + 1);
      mem_b[i] = 4'd1;
    end
    issue(5'(12), 8'd36, 10);
    wait_idle(15);

    // start pulsed during RUN is ignored: len=3, A=1, B=2 -> 6 after E5
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 4'd1;
      mem_b[i] = 4'd2;
    end
    issue(5'(3), 8'd6, 5);
    @(negedge clk);
    start = 1'b1;
    len   = 5'(1);
    @(negedge clk);
    start = 1'b0;
    wait_idle(10);
    repeat (3) @(negedge clk);

    // abort in the second RUN cycle: back to IDLE, no done, result stays 6
    start_only(5'(5));
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mac_reset", mac_reset, 1);
    chk("abort_addr", addr, 0);
    chk("abort_result", result, 6);
    repeat (10) @(negedge clk);
    chk("abort_result_later", result, 6);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    len   = 5'(2);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_mac_reset", mac_reset, 1);
    repeat (4) @(negedge clk);

    // async reset during DRAIN, then immediate restart
    mem_a[0] = 4'd3; mem_a[1] = 4'd5;
    mem_b[0] = 4'd2; mem_b[1] = 4'd4;
    start_only(5'(3));
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_addr", addr, 0);
    chk("arst_result", result, 0);
    chk("arst_mac_reset", mac_reset, 1);
    chk("arst_done", done, 0);
    chk("arst_mult", mult, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    len   = 5'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{res: 8'd26, cyc: cyc + 4});
    chk("restart_busy", busy, 1);
    wait_idle(10);

    repeat (5) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
